clk_div_lock: RTL and testbench

Parametrised, synthesisable clock-management block that replaces the pass-through PLL simulation model. It produces NUM_CH divided clocks at 50% duty from the system clock, with phases aligned at lock. It also models lock acquisition: LOCK_CYCLES cycles after enable, and again after every divisor change. Each channel has a divisor that can be reprogrammed at runtime over a valid/ready config port and a gate bit, and each channel emits a single-cycle `tick` for use as a clock enable.

---
 rtl/clk_div_lock.sv | 100 ++++++++++
 tb/tb_clk_div_lock.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_lock.sv
// clk_div_lock: lock-modelling divider that emits NUM_CH phase-aligned 50% clocks with edge ticks
module clk_div_lock #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 1,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              lock
);
    typedef enum logic [1:0] {OFF, LOCKING, LOCKED} state_t;
    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam int CW1 = CHW + 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [CHW:0] CH_LIMIT = CW1'(NUM_CH);
    state_t state;
    logic [LCW-1:0] lock_cnt;
    logic [DIV_W-1:0] div_q [NUM_CH];
    logic [DIV_W-1:0] cnt [NUM_CH];
    logic [DIV_W-1:0] last [NUM_CH];
    logic xfer, hit;
    assign cfg_ready = state != LOCKING;
    assign xfer = cfg_valid && cfg_ready;
    assign hit = xfer && ({1'b0, cfg_ch} < CH_LIMIT);
    // A divisor of 0 behaves as 1, so the wrap point saturates at 0
    always_comb
        for (int i = 0; i < NUM_CH; i++)
            last[i] = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state    <= OFF;
            lock_cnt <= '0;
            lock     <= 1'b0;
            clk_out  <= '0;
            tick     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                div_q[i] <= DIV_W'(DEFAULT_DIV);
            end
        end else begin
            if (hit)
                div_q[cfg_ch] <= cfg_div;
            tick <= '0;
            if (!en) begin
                state    <= OFF;
                lock_cnt <= '0;
                lock     <= 1'b0;
                clk_out  <= '0;
                for (int i = 0; i < NUM_CH; i++)
                    cnt[i] <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state    <= LOCKING;
                        lock_cnt <= '0;
                    end
                    LOCKING: begin
                        lock_cnt <= lock_cnt + 1'b1;
                        if (lock_cnt == LOCK_LAST) begin
                            state <= LOCKED;
                            lock  <= 1'b1;
                        end
                    end
                    LOCKED:
                        if (hit) begin
                            // a new divisor restarts every channel so they re-align after relock
                            state    <= LOCKING;
                            lock_cnt <= '0;
                            lock     <= 1'b0;
                            clk_out  <= '0;
                            for (int i = 0; i < NUM_CH; i++)
                                cnt[i] <= '0;
                        end else begin
                            for (int i = 0; i < NUM_CH; i++)
                                if (!ch_en[i]) begin
                                    cnt[i]     <= '0;
                                    clk_out[i] <= 1'b0;
                                end else if (cnt[i] == last[i]) begin
                                    cnt[i]     <= '0;
                                    clk_out[i] <= ~clk_out[i];
                                    tick[i]    <= ~clk_out[i];
                                end else begin
                                    cnt[i] <= cnt[i] + 1'b1;
                                end
                        end
                    default: state <= OFF;
                endcase
            end
        end
endmodule

// File: tb/tb_clk_div_lock.sv
// tb_clk_div_lock: randomized scoreboard bench; expected outputs come from an edge-count model
module tb_clk_div_lock;
    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int LC  = 16;
    localparam int DD  = 1;
    localparam int CW  = 2;
    typedef logic [2*NCH+1:0] obs_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b0;
    logic cfg_valid = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [CW-1:0] cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic cfg_ready, lock;
    logic [NCH-1:0] clk_out, tick;
    obs_t exp_q[$];
    obs_t ex, got;
    int checks = 0;
    int passed = 0;
    int phase = 0;
    int edge_no = 0;
    int a_edge = 0;
    int s_edge[NCH];
    int mdiv[NCH];

    clk_div_lock #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(DD)) dut (
        .clk(clk), .resetn(resetn), .en(en), .ch_en(ch_en), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out),
        .tick(tick), .lock(lock)
    );

    always #5 clk = ~clk;

    // phase: 0 off, 1 locking, 2 locked; a channel's output is a function of edges since s_edge
    task automatic step();
        int e, n, d;
        bit xf, good;
        logic [NCH-1:0] co, tk;
        e = edge_no;
        edge_no++;
        if (!resetn) begin
            phase = 0;
            for (int i = 0; i < NCH; i++) mdiv[i] = DD;
            exp_q.push_back(obs_t'(1));
            return;
        end
        xf = cfg_valid && (phase != 1);
        good = int'(cfg_ch) < NCH;
        if (xf && good) mdiv[cfg_ch] = int'(cfg_div);
        if (!en) phase = 0;
        else if (phase == 0) begin
            phase = 1;
            a_edge = e;
        end else if (phase == 1) begin
            if (e - a_edge == LC) begin
                phase = 2;
                for (int i = 0; i < NCH; i++) s_edge[i] = e;
            end
        end else if (xf && good) begin
            phase = 1;
            a_edge = e;
        end else begin
            for (int i = 0; i < NCH; i++) if (!ch_en[i]) s_edge[i] = e;
        end
        co = '0;
        tk = '0;
        if (phase == 2)
            for (int i = 0; i < NCH; i++) begin
                n = e - s_edge[i];
                d = (mdiv[i] == 0) ? 1 : mdiv[i];
                co[i] = ((n / d) % 2) == 1;
                tk[i] = (n > 0) && (n % (2 * d) == d);
            end
        exp_q.push_back({co, tk, phase == 2, phase != 1});
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            step();
            #1;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({clk_out, tick, lock, cfg_ready} === obs_t'(1)) passed++;
        else $display("FAIL async_reset got clk_out=%b tick=%b lock=%b ready=%b, need all 0 and ready=1",
                      clk_out, tick, lock, cfg_ready);
    endtask

    always @(negedge clk)
        if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            got = {clk_out, tick, lock, cfg_ready};
            checks++;
            if (got === ex) passed++;
            else $display("FAIL outputs t=%0t got clk_out=%b tick=%b lock=%b ready=%b need clk_out=%b tick=%b lock=%b ready=%b",
                          $time, got[2*NCH+1:NCH+2], got[NCH+1:2], got[1], got[0],
                          ex[2*NCH+1:NCH+2], ex[NCH+1:2], ex[1], ex[0]);
        end

    initial begin
        run(3);
        resetn = 1'b1;
        en = 1'b1;
        ch_en = '1;
        run(40);
        // divisors written while off, then enabled
        en = 1'b0;
        run(2);
        cfg_valid = 1'b1; cfg_ch = 0; cfg_div = 3;
        run(1);
        cfg_ch = 1; cfg_div = 5;
        run(1);
        cfg_valid = 1'b0;
        en = 1'b1;
        run(80);
        cfg_valid = 1'b1; cfg_ch = 1; cfg_div = 2;
        run(1);
        cfg_valid = 1'b0;
        run(40);
        // out-of-range channel must not relock; divisor 0 acts as 1
        cfg_valid = 1'b1; cfg_ch = 3; cfg_div = 9;
        run(1);
        cfg_valid = 1'b0;
        run(20);
        cfg_valid = 1'b1; cfg_ch = 0; cfg_div = 0;
        run(1);
        cfg_valid = 1'b0;
        run(30);
        run(3);
        ch_en[0] = 1'b0;
        run(6);
        ch_en[0] = 1'b1;
        run(10);
        cfg_valid = 1'b1; cfg_ch = 2; cfg_div = 4;
        run(1);
        run(3);
        cfg_valid = 1'b0;
        run(2);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(30);
        async_reset();
        run(2);
        resetn = 1'b1;
        run(40);
        cfg_valid = 1'b1; cfg_ch = 2; cfg_div = 255;
        run(1);
        cfg_valid = 1'b0;
        run(560);
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 59) == 0) ch_en[i] = ~ch_en[i];
            cfg_valid = $urandom_range(0, 39) == 0;
            cfg_ch = CW'($urandom_range(0, 3));
            cfg_div = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
                run(2);
                resetn = 1'b1;
            end
            run(1);
        end
        cfg_valid = 1'b0;
        en = 1'b0;
        run(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
